mem_access_ctrl: RTL and testbench
==================================

Name: mem_access_ctrl

Overview:
- Request-side controller directly upstream of the 32-bit little-endian word memory (16-bit word address, byte_sel, we/re, registered read).
- Accepts byte-addressed load/store requests of size byte, halfword or word over a valid/ready handshake.
- Sequences the memory's we/re strobes and performs read-modify-write for sub-word stores.
- Returns load data shifted down to bit 0, zero- or sign-extended, on a valid/ready response channel.

Parameters:
- ADDR_W, 18, byte-address width; word address = req_addr[ADDR_W-1:2] (ADDR_W-2 = 16 bits to memory).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  controller can accept; high only in IDLE
- req_write  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word, 11 reserved
- req_signed  in  1  loads only: sign-extend sub-word result
- req_addr  in  ADDR_W  byte address
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
- resp_valid  out  1  response present
- resp_ready  in  1  consumer takes response
- resp_rdata  out  32  load result; 0 for stores
- resp_err  out  1  request rejected, no memory access made
- mem_addr  out  16  word address to memory
- mem_byte_sel  out  2  req_addr[1:0] of current request
- mem_we  out  1  memory write strobe
- mem_re  out  1  memory read strobe
- mem_wdata  out  32  full word to write
- mem_rdata  in  32  memory read_data; valid the cycle after mem_re

Behaviour:
- Reset: state IDLE. All outputs 0 except req_ready = 1. Internal request registers cleared.
- Accept: on a clock edge with req_valid && req_ready, latch the request (addr, size, write, signed, wdata).
- mem_addr and mem_byte_sel are driven from the latched address in every non-IDLE state.
- States:
  - IDLE -> CHECK on accept.
  - CHECK: decode the request.
    - Invalid -> RESP with resp_err = 1.
    - Load -> READ.
    - Word store -> WRITE.
    - Sub-word store -> RMW_RD.
  - READ: mem_re = 1 for exactly one cycle -> CAPT.
  - CAPT: extract from mem_rdata.
    - Byte: lane = mem_rdata >> (8 * addr[1:0]).
    - Half: lane = mem_rdata >> (16 * addr[1]).
    - Word: mem_rdata unchanged.
    - Extend lane to 32 bits (sign if req_signed, else zero), register into resp_rdata -> RESP.
  - RMW_RD: mem_re = 1 one cycle -> MERGE.
  - MERGE: mem_wdata = mem_rdata with the addressed lane(s) replaced by req_wdata[7:0] or [15:0] -> WRITE.
  - WRITE: mem_we = 1 one cycle; mem_wdata = full req_wdata for word stores, merged word otherwise -> RESP.
  - RESP: resp_valid = 1 and held with resp_rdata/resp_err stable until resp_ready. On the handshake edge -> IDLE; resp_valid, resp_rdata, resp_err cleared.
- Strobes: mem_we and mem_re are never high together; each is high exactly one cycle per access.
- Latency (acceptance edge to resp_valid high, with resp_ready held high):
  - Load: 4 cycles.
  - Word store: 3 cycles.
  - Sub-word store: 5 cycles.
  - Error: 2 cycles.
- Throughput: next request can be accepted the cycle after the response handshake, since req_ready returns with IDLE.
- Invalid request:
  - req_size = 11 is always invalid.
  - Misaligned access is handled per MISALIGN_ERR_EN (see Optional Feature).
- Reset mid-operation: async return to IDLE; mem_we/mem_re drop immediately. A write whose WRITE edge already occurred stands; otherwise memory is untouched.
- Backpressure: resp_ready low holds RESP indefinitely; no further memory strobes.

Optional Feature:
- Macro: MISALIGN_ERR_EN.
- Defined: half with addr[0] = 1, or word with addr[1:0] != 0, is invalid -> resp_err = 1, resp_rdata = 0, no mem_re/mem_we.
- Undefined: misaligned address bits are ignored (half uses addr[1], word uses lane 0). The access proceeds normally and resp_err = 1 only for size 11.

Test Plan:
- Word store 0xDEADBEEF to byte addr 0x00010, then word load -> mem_addr = 4; resp_rdata = 0xDEADBEEF; resp_valid 4 cycles after load accept.
- Byte store 0x5A to addr 0x00012 over word 0x11223344 -> RMW: mem_re one cycle, mem_we with mem_wdata = 0x115A3344.
- Signed byte load at addr 0x00013 of word 0x80FF0000 -> resp_rdata = 0xFFFFFF80; same unsigned -> 0x00000080.
- Signed half load at addr 0x00012 of word 0x8001_7FFF -> 0xFFFF8001.
- req_size = 11, and (with MISALIGN_ERR_EN) word load at addr 0x00011 -> resp_err = 1, resp_rdata = 0, no mem strobes.
- resp_ready held low 5 cycles then high; rst_n pulsed low during RMW_RD -> response held stable until handshake; after reset, outputs 0, req_ready = 1, and no mem_we issued.

Source files
------------

// File: rtl/mem_access_ctrl_if.sv
// Request, response and memory-side signals of mem_access_ctrl.
// The slave modport is the controller's view; master is the surrounding system.
interface mem_access_ctrl_if #(
  parameter int ADDR_W = 18
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;

  logic              resp_valid;
  logic              resp_ready;
  logic [31:0]       resp_rdata;
  logic              resp_err;

  logic [ADDR_W-3:0] mem_addr;
  logic [1:0]        mem_byte_sel;
  logic              mem_we;
  logic              mem_re;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  modport slave (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    output req_ready,
    output resp_valid, resp_rdata, resp_err,
    input  resp_ready,
    output mem_addr, mem_byte_sel, mem_we, mem_re, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    input  req_ready,
    input  resp_valid, resp_rdata, resp_err,
    output resp_ready,
    input  mem_addr, mem_byte_sel, mem_we, mem_re, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// Byte/half/word load-store controller in front of a 32-bit word memory with registered read.
// Define MISALIGN_ERR_EN to reject misaligned half/word accesses instead of ignoring the low address bits.
module mem_access_ctrl #(
  parameter int ADDR_W = 18
) (
  input logic            clk,
  input logic            rst_n,
  mem_access_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    READ,
    CAPT,
    RMW_RD,
    MERGE,
    WRITE,
    RESP
  } state_t;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_t;

  state_t            state;
  logic [ADDR_W-1:0] r_addr;
  size_t             r_size;
  logic              r_write;
  logic              r_signed;
  logic [31:0]       r_wdata;
  logic              misaligned;

`ifdef MISALIGN_ERR_EN
  assign misaligned = ((r_size == SZ_HALF) && r_addr[0]) ||
                      ((r_size == SZ_WORD) && (r_addr[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  // Shift the addressed lane down to bit 0 and extend it to 32 bits.
  function automatic logic [31:0] extract(input logic [31:0] word, input size_t sz,
                                          input logic sgn, input logic [1:0] sel);
    // NOTE: every local gets a value before any branch so no path leaves it unassigned.
    logic [31:0] lane;
    lane = word;
    case (sz)
      SZ_BYTE: begin
        lane = word >> {sel, 3'b000};
        return {{24{sgn & lane[7]}}, lane[7:0]};
      end
      SZ_HALF: begin
        lane = word >> {sel[1], 4'b0000};
        return {{16{sgn & lane[15]}}, lane[15:0]};
      end
      default: return lane;
    endcase
  endfunction

  // Replace the addressed lane(s) of the old word with right-aligned store data.
  function automatic logic [31:0] merge(input logic [31:0] word, input logic [31:0] data,
                                        input size_t sz, input logic [1:0] sel);
    logic [31:0] m;
    m = word;
    case (sz)
      SZ_BYTE: m[{sel, 3'b000} +: 8]         = data[7:0];
      SZ_HALF: m[{sel[1], 4'b0000} +: 16]    = data[15:0];
      default: m                             = data;
    endcase
    return m;
  endfunction

  // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: every register, including the latched request, is reset; no storage here is left to power-up values.
      state            <= IDLE;
      r_addr           <= '0;
      r_size           <= SZ_BYTE;
      r_write          <= 1'b0;
      r_signed         <= 1'b0;
      r_wdata          <= '0;
      bus.req_ready    <= 1'b1;
      bus.resp_valid   <= 1'b0;
      bus.resp_rdata   <= '0;
      bus.resp_err     <= 1'b0;
      bus.mem_addr     <= '0;
      bus.mem_byte_sel <= '0;
      bus.mem_we       <= 1'b0;
      bus.mem_re       <= 1'b0;
      bus.mem_wdata    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            r_addr           <= bus.req_addr;
            r_size           <= size_t'(bus.req_size);
            r_write          <= bus.req_write;
            r_signed         <= bus.req_signed;
            r_wdata          <= bus.req_wdata;
            bus.mem_addr     <= bus.req_addr[ADDR_W-1:2];
            bus.mem_byte_sel <= bus.req_addr[1:0];
            bus.req_ready    <= 1'b0;
            state            <= CHECK;
          end
        end

        CHECK: begin
          if ((r_size == SZ_RSVD) || misaligned) begin
            bus.resp_err   <= 1'b1;
            bus.resp_rdata <= '0;
            bus.resp_valid <= 1'b1;
            state          <= RESP;
          end else if (!r_write) begin
            bus.mem_re <= 1'b1;
            state      <= READ;
          end else if (r_size == SZ_WORD) begin
            bus.mem_we    <= 1'b1;
            bus.mem_wdata <= r_wdata;
            state         <= WRITE;
          end else begin
            bus.mem_re <= 1'b1;
            state      <= RMW_RD;
          end
        end

        READ: begin
          bus.mem_re <= 1'b0;
          state      <= CAPT;
        end

        CAPT: begin
          bus.resp_rdata <= extract(bus.mem_rdata, r_size, r_signed, r_addr[1:0]);
          bus.resp_valid <= 1'b1;
          state          <= RESP;
        end

        RMW_RD: begin
          bus.mem_re <= 1'b0;
          state      <= MERGE;
        end

        MERGE: begin
          bus.mem_wdata <= merge(bus.mem_rdata, r_wdata, r_size, r_addr[1:0]);
          bus.mem_we    <= 1'b1;
          state         <= WRITE;
        end

        WRITE: begin
          bus.mem_we     <= 1'b0;
          bus.mem_wdata  <= '0;
          bus.resp_rdata <= '0;
          bus.resp_valid <= 1'b1;
          state          <= RESP;
        end

        RESP: begin
          // Response and address stay frozen until the consumer takes them.
          if (bus.resp_ready) begin
            bus.resp_valid   <= 1'b0;
            bus.resp_rdata   <= '0;
            bus.resp_err     <= 1'b0;
            bus.mem_addr     <= '0;
            bus.mem_byte_sel <= '0;
            bus.req_ready    <= 1'b1;
            state            <= IDLE;
          end
        end

        default: begin
          bus.req_ready <= 1'b1;
          state         <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: the driver queues expected responses, a monitor
// pops and compares them, including latency, strobe counts and the written word.
module tb_mem_access_ctrl;
  localparam int ADDR_W = 18;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          re;
    int          we;
    logic [15:0] maddr;
    logic [31:0] wdata;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_access_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

  mem_access_ctrl #(.ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Word memory model with registered read.
  logic [31:0] mem [0:65535] = '{default: 32'h0};
  always @(posedge clk) begin
    if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
    if (bus.mem_re) bus.mem_rdata <= mem[bus.mem_addr];
  end

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  exp_t        q[$];
  exp_t        cur;
  bit          have_cur = 0;
  int          acc_cyc  = 0;
  int          re_cnt   = 0;
  int          we_cnt   = 0;
  logic [15:0] re_addr  = '0;
  logic [15:0] we_addr  = '0;
  logic [31:0] we_data  = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic exp_t mk(input logic [31:0] rdata, input logic err, input int lat,
                              input int re, input int we, input logic [15:0] maddr,
                              input logic [31:0] wdata);
    exp_t e;
    e.rdata = rdata; e.err = err; e.lat = lat; e.re = re; e.we = we;
    e.maddr = maddr; e.wdata = wdata;
    return e;
  endfunction

  // Monitor: samples on the falling edge, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        have_cur = 0;
        continue;
      end
      if (bus.mem_re || bus.mem_we) check("strobe_excl", 32'(bus.mem_re & bus.mem_we), 32'd0);
      if (bus.mem_re) begin re_cnt++; re_addr = bus.mem_addr; end
      if (bus.mem_we) begin we_cnt++; we_addr = bus.mem_addr; we_data = bus.mem_wdata; end
      if (bus.resp_valid) begin
        if (!have_cur) begin
          check("resp_expected", 32'(q.size() != 0), 32'd1);
          if (q.size() != 0) begin
            cur = q.pop_front();
            have_cur = 1;
            check("resp_rdata", bus.resp_rdata, cur.rdata);
            check("resp_err", 32'(bus.resp_err), 32'(cur.err));
            check("latency", 32'(cyc - acc_cyc + 1), 32'(cur.lat));
            check("re_count", 32'(re_cnt), 32'(cur.re));
            check("we_count", 32'(we_cnt), 32'(cur.we));
            if (cur.re != 0 || cur.we != 0)
              check("mem_addr", 32'(cur.we != 0 ? we_addr : re_addr), 32'(cur.maddr));
            if (cur.we != 0) check("mem_wdata", we_data, cur.wdata);
          end
        end else begin
          check("hold_rdata", bus.resp_rdata, cur.rdata);
          check("hold_err", 32'(bus.resp_err), 32'(cur.err));
        end
        if (bus.resp_ready) have_cur = 0;
      end
      if (bus.req_valid && bus.req_ready) begin
        acc_cyc = cyc + 1;
        re_cnt  = 0;
        we_cnt  = 0;
      end
    end
  end

  task automatic send(input logic w, input logic [1:0] sz, input logic sg,
                      input logic [17:0] a, input logic [31:0] d,
                      input exp_t e, input bit push);
    bit ok = 0;
    if (push) q.push_back(e);
    bus.req_write  = w;
    bus.req_size   = sz;
    bus.req_signed = sg;
    bus.req_addr   = a;
    bus.req_wdata  = d;
    bus.req_valid  = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.req_ready) begin ok = 1; break; end
    end
    check("accept_timeout", 32'(ok), 32'd1);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_done();
    bit ok = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (bus.resp_valid && bus.resp_ready) begin ok = 1; break; end
    end
    check("resp_timeout", 32'(ok), 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic txn(input logic w, input logic [1:0] sz, input logic sg,
                     input logic [17:0] a, input logic [31:0] d, input exp_t e);
    send(w, sz, sg, a, d, e, 1'b1);
    wait_done();
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_req_ready"},  32'(bus.req_ready), 32'd1);
    check({tag, "_resp_valid"}, 32'(bus.resp_valid), 32'd0);
    check({tag, "_resp_rdata"}, bus.resp_rdata, 32'd0);
    check({tag, "_resp_err"},   32'(bus.resp_err), 32'd0);
    check({tag, "_mem_we"},     32'(bus.mem_we), 32'd0);
    check({tag, "_mem_re"},     32'(bus.mem_re), 32'd0);
    check({tag, "_mem_addr"},   32'(bus.mem_addr), 32'd0);
    check({tag, "_byte_sel"},   32'(bus.mem_byte_sel), 32'd0);
    check({tag, "_mem_wdata"},  bus.mem_wdata, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_valid  = 1'b0;
    bus.req_write  = 1'b0;
    bus.req_size   = 2'b00;
    bus.req_signed = 1'b0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.resp_ready = 1'b1;

    #12;
    check_idle_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Word store / load round trip.
    txn(1, 2'b10, 0, 18'h00010, 32'hDEADBEEF, mk(32'h0, 0, 3, 0, 1, 16'h4, 32'hDEADBEEF));
    txn(0, 2'b10, 0, 18'h00010, 32'h0,        mk(32'hDEADBEEF, 0, 4, 1, 0, 16'h4, 32'h0));

    // Byte read-modify-write; upper store-data bits must be ignored.
    txn(1, 2'b10, 0, 18'h00010, 32'h11223344, mk(32'h0, 0, 3, 0, 1, 16'h4, 32'h11223344));
    txn(1, 2'b00, 0, 18'h00012, 32'hFFFFFF5A, mk(32'h0, 0, 5, 1, 1, 16'h4, 32'h115A3344));
    txn(0, 2'b10, 0, 18'h00010, 32'h0,        mk(32'h115A3344, 0, 4, 1, 0, 16'h4, 32'h0));

    // Byte loads, signed and unsigned.
    txn(1, 2'b10, 0, 18'h00010, 32'h80FF0000, mk(32'h0, 0, 3, 0, 1, 16'h4, 32'h80FF0000));
    txn(0, 2'b00, 1, 18'h00013, 32'h0, mk(32'hFFFFFF80, 0, 4, 1, 0, 16'h4, 32'h0));
    txn(0, 2'b00, 0, 18'h00013, 32'h0, mk(32'h00000080, 0, 4, 1, 0, 16'h4, 32'h0));
    txn(0, 2'b00, 1, 18'h00012, 32'h0, mk(32'hFFFFFFFF, 0, 4, 1, 0, 16'h4, 32'h0));
    txn(0, 2'b00, 1, 18'h00010, 32'h0, mk(32'h00000000, 0, 4, 1, 0, 16'h4, 32'h0));

    // Half loads and half read-modify-write.
    txn(1, 2'b10, 0, 18'h00010, 32'h80017FFF, mk(32'h0, 0, 3, 0, 1, 16'h4, 32'h80017FFF));
    txn(0, 2'b01, 1, 18'h00012, 32'h0, mk(32'hFFFF8001, 0, 4, 1, 0, 16'h4, 32'h0));
    txn(0, 2'b01, 0, 18'h00012, 32'h0, mk(32'h00008001, 0, 4, 1, 0, 16'h4, 32'h0));
    txn(0, 2'b01, 1, 18'h00010, 32'h0, mk(32'h00007FFF, 0, 4, 1, 0, 16'h4, 32'h0));
    txn(1, 2'b01, 0, 18'h00012, 32'h1234BEEF, mk(32'h0, 0, 5, 1, 1, 16'h4, 32'hBEEF7FFF));
    txn(0, 2'b10, 0, 18'h00010, 32'h0, mk(32'hBEEF7FFF, 0, 4, 1, 0, 16'h4, 32'h0));

    // Reserved size: rejected with no memory access, memory unchanged.
    txn(0, 2'b11, 0, 18'h00010, 32'h0,        mk(32'h0, 1, 2, 0, 0, 16'h4, 32'h0));
    txn(1, 2'b11, 0, 18'h00010, 32'hCAFEF00D, mk(32'h0, 1, 2, 0, 0, 16'h4, 32'h0));
    txn(0, 2'b10, 0, 18'h00010, 32'h0, mk(32'hBEEF7FFF, 0, 4, 1, 0, 16'h4, 32'h0));

    // Misaligned accesses.
`ifdef MISALIGN_ERR_EN
    txn(0, 2'b10, 0, 18'h00011, 32'h0, mk(32'h0, 1, 2, 0, 0, 16'h4, 32'h0));
    txn(0, 2'b01, 1, 18'h00013, 32'h0, mk(32'h0, 1, 2, 0, 0, 16'h4, 32'h0));
`else
    txn(0, 2'b10, 0, 18'h00011, 32'h0, mk(32'hBEEF7FFF, 0, 4, 1, 0, 16'h4, 32'h0));
    txn(0, 2'b01, 1, 18'h00013, 32'h0, mk(32'hFFFFBEEF, 0, 4, 1, 0, 16'h4, 32'h0));
`endif

    // Top of the address space.
    txn(1, 2'b10, 0, 18'h3FFFC, 32'h0BADF00D, mk(32'h0, 0, 3, 0, 1, 16'hFFFF, 32'h0BADF00D));
    txn(0, 2'b00, 1, 18'h3FFFF, 32'h0, mk(32'h0000000B, 0, 4, 1, 0, 16'hFFFF, 32'h0));

    // Backpressure: response held stable, no extra strobes.
    bus.resp_ready = 1'b0;
    send(0, 2'b10, 0, 18'h00010, 32'h0, mk(32'hBEEF7FFF, 0, 4, 1, 0, 16'h4, 32'h0), 1'b1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.resp_valid) break;
    end
    repeat (5) @(posedge clk);
    #1;
    check("hold_re_count", 32'(re_cnt), 32'd1);
    check("hold_we_count", 32'(we_cnt), 32'd0);
    bus.resp_ready = 1'b1;
    wait_done();
    check_idle_outputs("post_hold");

    // Reset during RMW_RD: strobes drop at once, memory untouched.
    send(1, 2'b00, 0, 18'h00010, 32'h00000077, mk(32'h0, 0, 0, 0, 0, 16'h0, 32'h0), 1'b0);
    @(posedge clk);
    #1;
    check("rmw_rd_reached", 32'(bus.mem_re), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_idle_outputs("async_rst");
    repeat (3) @(negedge clk);
    check("rst_no_we", 32'(we_cnt), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check_idle_outputs("after_rst");
    @(posedge clk);
    #1;
    txn(0, 2'b10, 0, 18'h00010, 32'h0, mk(32'hBEEF7FFF, 0, 4, 1, 0, 16'h4, 32'h0));
    check("queue_drained", 32'(q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
